// File: rtl/ans_stage_combiner.sv
// Aligns four sign-magnitude stage corrections, sums them and saturates the result to OUT_W bits.
// Latency: 3 clocks from in_vld to out_vld; accepts a new sample every cycle. Build option: ANS_STAGE_COMBINER_SATCNT_EN.
// Backpressure: none; the output driver must accept every out_vld strobe.
module ans_stage_combiner #(
    parameter int NIN   = 4,
    parameter int DLY0  = 3,
    parameter int DLY1  = 2,
    parameter int DLY2  = 1,
    parameter int DLY3  = 0,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [15:0]      C0,
    input  logic [15:0]      C1,
    input  logic [15:0]      C2,
    input  logic [15:0]      C3,
    input  logic             Csgn0,
    input  logic             Csgn1,
    input  logic             Csgn2,
    input  logic             Csgn3,
    output logic [OUT_W-1:0] sum,
    output logic             out_vld,
    output logic             sat,
    output logic             primed
`ifdef ANS_STAGE_COMBINER_SATCNT_EN
    ,
    input  logic             sat_clr,
    output logic [15:0]      sat_cnt
`endif
);

    localparam int M01  = (DLY0 > DLY1) ? DLY0 : DLY1;
    localparam int M23  = (DLY2 > DLY3) ? DLY2 : DLY3;
    localparam int MAXD = (M01 > M23) ? M01 : M23;
    localparam logic [3:0] MAXD4 = 4'(MAXD);
    localparam int MAXI = (1 << (OUT_W - 1)) - 1;
    localparam int MINI = -(1 << (OUT_W - 1));
    localparam logic [OUT_W-1:0] MAXW = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] MINW = {1'b1, {(OUT_W - 1){1'b0}}};

    logic        [15:0] mag  [NIN];
    logic               sgn  [NIN];
    logic signed [16:0] term [NIN];
    logic signed [16:0] tap  [NIN];
    logic signed [16:0] t    [NIN];
    logic signed [17:0] p01, p23;
    logic signed [18:0] full;
    logic signed [31:0] full_ext;
    logic               clip_hi, clip_lo;
    logic [OUT_W-1:0]   clipped;
    logic [3:0]         pcnt;
    logic               take, v1, v2;

    assign mag[0] = C0;
    assign mag[1] = C1;
    assign mag[2] = C2;
    assign mag[3] = C3;
    assign sgn[0] = Csgn0;
    assign sgn[1] = Csgn1;
    assign sgn[2] = Csgn2;
    assign sgn[3] = Csgn3;

    // Negating a zero magnitude yields plain zero, so no -0 can escape.
    always_comb begin
        for (int i = 0; i < NIN; i++) begin
            term[i] = $signed({1'b0, mag[i]});
            if (sgn[i]) term[i] = -term[i];
        end
    end

    for (genvar gi = 0; gi < NIN; gi++) begin : g_dl
        localparam int D = (gi == 0) ? DLY0 : (gi == 1) ? DLY1 : (gi == 2) ? DLY2 : DLY3;
        if (D == 0) begin : g_nodly
            assign tap[gi] = term[gi];
        end else begin : g_dly
            logic signed [16:0] sr [D];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) sr[k] <= '0;
                end else if (in_vld) begin
                    sr[0] <= term[gi];
                    for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
                end
            end
            assign tap[gi] = sr[D-1];
        end
    end

    // A sample only produces output once every delay line holds real history.
    assign take = in_vld && (pcnt == MAXD4);

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (in_vld && (pcnt != MAXD4)) begin
            pcnt <= pcnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NIN; i++) t[i] <= '0;
            p01 <= '0;
            p23 <= '0;
            v1  <= 1'b0;
            v2  <= 1'b0;
        end else begin
            if (in_vld) begin
                for (int i = 0; i < NIN; i++) t[i] <= tap[i];
            end
            p01 <= 18'(t[0]) + 18'(t[1]);
            p23 <= 18'(t[2]) + 18'(t[3]);
            v1  <= take;
            v2  <= v1;
        end
    end

    assign full     = 19'(p01) + 19'(p23);
    assign full_ext = 32'(full);
    assign clip_hi  = full_ext > MAXI;
    assign clip_lo  = full_ext < MINI;
    assign clipped  = clip_hi ? MAXW : (clip_lo ? MINW : full[OUT_W-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum     <= '0;
            out_vld <= 1'b0;
            sat     <= 1'b0;
            primed  <= 1'b0;
        end else begin
            out_vld <= v2;
            sat     <= v2 && (clip_hi || clip_lo);
            primed  <= primed || v2;
            if (v2) sum <= clipped;
        end
    end

`ifdef ANS_STAGE_COMBINER_SATCNT_EN
    always_ff @(posedge clk) begin
        if (rst || sat_clr) begin
            sat_cnt <= '0;
        end else if (v2 && (clip_hi || clip_lo) && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ans_stage_combiner.sv
// Bench for ans_stage_combiner: a default-parameter instance and a zero-delay OUT_W=19 instance share stimulus.
// Expected outputs come from a strobe-history model; outputs are sampled 1ns after each rising edge.
module tb_ans_stage_combiner;

    logic        clk = 1'b0;
    logic        rst, in_vld;
    logic [15:0] c0, c1, c2, c3;
    logic        s0, s1, s2, s3;
    logic [15:0] sum_a;
    logic [18:0] sum_b;
    logic        vld_a, sat_a, prim_a_o, vld_b, sat_b, prim_b_o;
`ifdef ANS_STAGE_COMBINER_SATCNT_EN
    logic        sat_clr;
    logic [15:0] sat_cnt_a, sat_cnt_b;
`endif

    always #5 clk = ~clk;

    ans_stage_combiner u_dut (
        .clk(clk), .rst(rst), .in_vld(in_vld),
        .C0(c0), .C1(c1), .C2(c2), .C3(c3),
        .Csgn0(s0), .Csgn1(s1), .Csgn2(s2), .Csgn3(s3),
        .sum(sum_a), .out_vld(vld_a), .sat(sat_a), .primed(prim_a_o)
`ifdef ANS_STAGE_COMBINER_SATCNT_EN
        , .sat_clr(sat_clr), .sat_cnt(sat_cnt_a)
`endif
    );

    ans_stage_combiner #(.DLY0(0), .DLY1(0), .DLY2(0), .DLY3(0), .OUT_W(19)) u_zero (
        .clk(clk), .rst(rst), .in_vld(in_vld),
        .C0(c0), .C1(c1), .C2(c2), .C3(c3),
        .Csgn0(s0), .Csgn1(s1), .Csgn2(s2), .Csgn3(s3),
        .sum(sum_b), .out_vld(vld_b), .sat(sat_b), .primed(prim_b_o)
`ifdef ANS_STAGE_COMBINER_SATCNT_EN
        , .sat_clr(sat_clr), .sat_cnt(sat_cnt_b)
`endif
    );

    typedef struct packed {
        logic [3:0][15:0] c;
        logic [3:0]       s;
    } smp_t;

    typedef struct {
        bit v;
        int s;
        bit sat;
    } exp_t;

    smp_t hist[$];
    exp_t qa[$], qb[$];
    int   total = 0;
    int   bad = 0;
    int   last_a, last_b;
    bit   prim_a, prim_b;

    // Output for the newest strobe: each input contributes its value from dly strobes back.
    function automatic exp_t model(int d0, int d1, int d2, int d3, int ow);
        exp_t e;
        int   d[4];
        int   n, maxd, tot, hi, lo, mag;
        smp_t h;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        maxd = 0;
        for (int i = 0; i < 4; i++) if (d[i] > maxd) maxd = d[i];
        n = hist.size() - 1;
        e.v = 0; e.s = 0; e.sat = 0;
        if (n < maxd) return e;
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            h = hist[n - d[i]];
            mag = int'(h.c[i]);
            tot += h.s[i] ? -mag : mag;
        end
        hi = (1 << (ow - 1)) - 1;
        lo = -(1 << (ow - 1));
        e.v = 1;
        if (tot > hi) begin e.s = hi; e.sat = 1; end
        else if (tot < lo) begin e.s = lo; e.sat = 1; end
        else e.s = tot;
        return e;
    endfunction

    task automatic chk(string tag, int obs, int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.v = 0; e.s = 0; e.sat = 0;
        return e;
    endfunction

    task automatic step(bit v, logic [3:0][15:0] c, logic [3:0] s);
        exp_t ea, eb;
        in_vld = v;
        c0 = c[0]; c1 = c[1]; c2 = c[2]; c3 = c[3];
        s0 = s[0]; s1 = s[1]; s2 = s[2]; s3 = s[3];
        if (v) begin
            hist.push_back({c, s});
            qa.push_back(model(3, 2, 1, 0, 16));
            qb.push_back(model(0, 0, 0, 0, 19));
        end else begin
            qa.push_back(idle_exp());
            qb.push_back(idle_exp());
        end
        @(posedge clk);
        #1;
        if (qa.size() == 3) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            if (ea.v) begin last_a = ea.s; prim_a = 1; end
            if (eb.v) begin last_b = eb.s; prim_b = 1; end
            chk("a_vld", int'(vld_a), int'(ea.v));
            chk("a_sum", int'($signed(sum_a)), last_a);
            chk("a_sat", int'(sat_a), int'(ea.v && ea.sat));
            chk("a_primed", int'(prim_a_o), int'(prim_a));
            chk("b_vld", int'(vld_b), int'(eb.v));
            chk("b_sum", int'($signed(sum_b)), last_b);
            chk("b_sat", int'(sat_b), int'(eb.v && eb.sat));
            chk("b_primed", int'(prim_b_o), int'(prim_b));
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0);
    endtask

    // Reset is held with in_vld high to show reset wins over a strobe.
    task automatic do_reset();
        rst = 1'b1;
        in_vld = 1'b1;
        c0 = 16'($urandom); c1 = 16'($urandom); c2 = 16'($urandom); c3 = 16'($urandom);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum_a", int'(sum_a), 0);
        chk("rst_vld_a", int'(vld_a), 0);
        chk("rst_sat_a", int'(sat_a), 0);
        chk("rst_primed_a", int'(prim_a_o), 0);
        chk("rst_sum_b", int'(sum_b), 0);
        chk("rst_vld_b", int'(vld_b), 0);
        chk("rst_primed_b", int'(prim_b_o), 0);
`ifdef ANS_STAGE_COMBINER_SATCNT_EN
        chk("rst_sat_cnt", int'(sat_cnt_a), 0);
`endif
        rst = 1'b0;
        in_vld = 1'b0;
        hist.delete();
        qa.delete();
        qb.delete();
        for (int i = 0; i < 2; i++) begin
            qa.push_back(idle_exp());
            qb.push_back(idle_exp());
        end
        last_a = 0; last_b = 0;
        prim_a = 0; prim_b = 0;
    endtask

    initial begin
        logic [3:0][15:0] rc;
        logic [6:0]       pat;
        int               ramp;
        rst = 1'b1; in_vld = 1'b0;
        c0 = '0; c1 = '0; c2 = '0; c3 = '0;
        s0 = 1'b0; s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
`ifdef ANS_STAGE_COMBINER_SATCNT_EN
        sat_clr = 1'b0;
`endif

        // priming with all-ones inputs: first output on the 4th strobe, sum 4
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, {4{16'h0001}}, 4'b0000);

        // mixed signs, including a negative-zero term on input 2
        step(1'b1, {16'd7, 16'd0, 16'd50, 16'd100}, 4'b0110);
        idle(3);

        // full-scale positive then negative: clipped at OUT_W=16, exact at OUT_W=19
        for (int i = 0; i < 4; i++) step(1'b1, {4{16'hFFFF}}, 4'b0000);
        for (int i = 0; i < 4; i++) step(1'b1, {4{16'hFFFF}}, 4'b1111);
        idle(3);

        // gapped strobes with a ramp on input 0
        do_reset();
        pat = 7'b1011001;
        ramp = 1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 7; i++) begin
                if (pat[i]) begin
                    step(1'b1, {16'd0, 16'd0, 16'd0, 16'(ramp)}, 4'b0000);
                    ramp++;
                end else begin
                    step(1'b0, '0, '0);
                end
            end
        end
        idle(3);

        // reset with two samples in flight, then priming restarts from zero
        step(1'b1, {4{16'h0003}}, 4'b0000);
        step(1'b1, {4{16'h0005}}, 4'b0001);
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, {4{16'(i + 10)}}, 4'(i));
        idle(3);

        // random traffic, biased toward large magnitudes so clipping occurs
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++)
                rc[i] = ($urandom_range(0, 1) == 1) ? 16'(16'hFFFF - $urandom_range(0, 4095)) : 16'($urandom);
            step($urandom_range(0, 3) != 0, rc, 4'($urandom));
        end
        idle(3);

`ifdef ANS_STAGE_COMBINER_SATCNT_EN
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, '0, '0);
        for (int i = 0; i < 5; i++) step(1'b1, {4{16'hFFFF}}, 4'b0000);
        idle(3);
        chk("sat_cnt_5", int'(sat_cnt_a), 5);
        chk("sat_cnt_b_zero", int'(sat_cnt_b), 0);
        step(1'b1, {4{16'hFFFF}}, 4'b0000);
        step(1'b0, '0, '0);
        sat_clr = 1'b1;
        step(1'b0, '0, '0);
        sat_clr = 1'b0;
        chk("sat_cnt_clr", int'(sat_cnt_a), 0);
        for (int i = 0; i < 70000; i++) step(1'b1, {4{16'hFFFF}}, 4'b1111);
        idle(3);
        chk("sat_cnt_max", int'(sat_cnt_a), 32'h0000FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ans_stage_combiner.md
Name: ans_stage_combiner

Overview:
- Sink end of the per-stage correction path. Each ANS-PWM stage emits a delayed-difference correction as a 16-bit magnitude C plus a sign bit Csgn.
- This block time-aligns the four stage corrections with per-input sample delays and converts each from sign-magnitude to two's complement.
- It sums the aligned terms, saturates the sum, and presents one signed word per sample to the PWM output driver.
- It performs the final signed addition that the stages feed.

Parameters:
- NIN, 4, number of stage inputs (fixed at 4 for this revision).
- DLY0, 3, sample delay applied to input 0 (0..15).
- DLY1, 2, sample delay applied to input 1 (0..15).
- DLY2, 1, sample delay applied to input 2 (0..15).
- DLY3, 0, sample delay applied to input 3 (0..15).
- OUT_W, 16, signed output width (8..19).

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  1  sample strobe; all C/Csgn inputs are valid in this cycle.
- C0..C3  in  16 each  stage correction magnitudes.
- Csgn0..Csgn3  in  1 each  stage correction signs; 1 = negative.
- sum  out  OUT_W  saturated signed sum, two's complement.
- out_vld  out  1  one-cycle strobe; sum is valid.
- sat  out  1  high with out_vld when the sample was clipped.
- primed  out  1  delay lines filled; stays high until reset.

Behaviour:
- Reset:
  - sum=0, out_vld=0, sat=0, primed=0.
  - All delay-line entries and pipeline registers are cleared to 0.
  - Prime counter is cleared to 0.
  - Reset overrides in_vld in the same cycle.
  - Reset mid-pipeline discards in-flight samples: no out_vld for them.
- Conversion:
  - Term = Csgn ? -C : +C, sign-extended to 17 bits.
  - Magnitude 0 with Csgn=1 yields 0 (no negative zero).
- Delay lines:
  - Input i goes through a shift register of depth DLYi.
  - Shifting happens only on in_vld edges, not on every clock.
  - DLYi=0 means the current sample is used directly.
  - The tap used is the value captured DLYi strobes earlier.
- Pipeline, for a sample presented with in_vld at cycle T:
  - T+1: registered aligned terms t0..t3.
  - T+2: partial sums p01=t0+t1 and p23=t2+t3, each 18 bits.
  - T+3: full=p01+p23 (19 bits), then saturation.
  - sum and out_vld are registered and visible in cycle T+3.
  - Fixed latency is 3 clocks. Back-to-back in_vld every cycle is supported at full throughput, with no bubbles.
- Saturation:
  - Clamp to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
  - sat=1 in the same cycle as out_vld when clamped; otherwise sat=0.
  - With OUT_W=19, sat is never asserted.
- Priming:
  - The 4-bit counter increments on each in_vld until it reaches MAXD = max(DLY0..DLY3).
  - primed goes high with the out_vld of the sample on which the count reached MAXD.
  - out_vld is suppressed for samples processed before priming, so MAXD strobes produce no output.
  - If MAXD=0, primed rises with the first out_vld.
- in_vld=0 cycles: no shift, no counter change, out_vld=0 three cycles later. sum holds its last value.
- No backpressure: the downstream side must accept every out_vld.

Optional Feature:
- Macro: ANS_STAGE_COMBINER_SATCNT_EN.
- When defined, the block adds:
  - Output port sat_cnt, out, 16 bits.
  - Input port sat_clr, in, 1 bit.
  - sat_cnt increments on each out_vld with sat=1 and saturates at 0xFFFF (no wrap).
  - sat_clr=1 zeroes sat_cnt. If sat_clr and a saturating sample arrive in the same cycle, sat_cnt becomes 0 (clear wins).
  - Reset zeroes sat_cnt.
- When not defined, neither port exists and no counter logic is built. All other behaviour is identical.

Test Plan:
- Defaults, rst for 2 cycles, then in_vld every cycle with all C=0x0001, Csgn=0:
  - No out_vld for the first 3 samples.
  - The 4th sample gives out_vld at T+3 with sum=4 and primed=1.
- DLY all 0, one strobe with C0=100, C1=50, Csgn1=1, C2=0, Csgn2=1, C3=7: sum=57 exactly 3 clocks later, sat=0, and no -0 artifact from input 2.
- OUT_W=16, all C=0xFFFF, Csgn=0: sum=0x7FFF, sat=1. With all Csgn=1 instead: sum=0x8000, sat=1.
- Defaults, in_vld with a gap pattern 1,0,0,1,1,0,1, ramp on C0 (1,2,3,…), other inputs 0: the sum sequence equals the C0 ramp delayed by 3 strobes. The out_vld pattern mirrors in_vld with a 3-clock shift.
- rst asserted while 2 samples are in flight: no out_vld for them, primed=0, and the priming sequence restarts from 0 strobes.
- With ANS_STAGE_COMBINER_SATCNT_EN:
  - 5 saturating samples give sat_cnt=5.
  - sat_clr pulsed in the same cycle as a 6th saturating sample gives sat_cnt=0.
  - 70000 saturating samples give sat_cnt=0xFFFF.
